keypad_operand_entry: RTL and testbench
=======================================

Name: keypad_operand_entry

Overview:
Input-side counterpart to the seven-segment display path. It scans a 4x4 hex matrix keypad by driving columns and reading rows, then debounces the result. Accepted key codes are loaded alternately into the A and B operand registers that feed the adder/subtractor. It runs on clk_main beside the display driver and replaces the slide-switch operand inputs.

Parameters:
SCAN_DIV, 5000, clk_main cycles per column slot; must be >= 4.
DEBOUNCE_SCANS, 4, consecutive identical full scans needed to accept a press or a release; must be >= 1.

Ports:
clk_main  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
kp_rows  input  4  keypad rows, active-low (external pull-ups), asynchronous to clk_main.
kp_cols  output  4  column drive, active-low, one-hot-low.
clear  input  1  synchronous; returns the entry FSM to ENTER_A.
op_a  output  4  operand A register.
op_b  output  4  operand B register.
entry_b  output  1  0 = next key loads A, 1 = next key loads B.
key_valid  output  1  one-cycle pulse per accepted key.
key_code  output  4  code of the last accepted key.
operands_ready  output  1  one-cycle pulse when B has been loaded.

Behaviour:
- Reset values: kp_cols=4'b1110, op_a=0, op_b=0, entry_b=0, key_valid=0, key_code=0, operands_ready=0. Scan counter, column index, debounce counter and press-latch all 0; row synchronizer flops reset to 1.
- kp_rows passes through a 2-flop synchronizer; all decisions use the synchronized value.
- Scan:
  - Column c (0..3) is driven low for SCAN_DIV cycles.
  - Rows are sampled on the last cycle of each slot, then the column index advances, wrapping 3->0.
  - One full scan = 4*SCAN_DIV cycles.
- Scan result, evaluated after the column-3 sample:
  - NONE: no bits low.
  - SINGLE: exactly one bit low across the 4x4 sample; code = 4*row + col.
  - MULTI: two or more bits low.
- Debounce / press latch:
  - Released state, result SINGLE with the same code as the previous scan: increment the stable count.
  - Released state, any other result: stable count = 1 for SINGLE, 0 otherwise.
  - Stable count reaching DEBOUNCE_SCANS: key_valid=1 for the next cycle, key_code updates on that cycle, enter pressed state.
  - Pressed state: no further key_valid, whatever is held (no auto-repeat, a second key added is ignored).
  - Release requires DEBOUNCE_SCANS consecutive NONE scans; then return to released state with stable count 0.
  - MULTI resets the stable count and never emits.
- Latency: for a clean press, key_valid is asserted within (DEBOUNCE_SCANS+1)*4*SCAN_DIV+3 cycles of the row change at the pins.
- Entry FSM, states ENTER_A (entry_b=0) and ENTER_B (entry_b=1):
  - key_valid in ENTER_A: op_a<=key_code, go to ENTER_B.
  - key_valid in ENTER_B: op_b<=key_code, go to ENTER_A, operands_ready=1 in the same cycle as key_valid.
  - op_a/op_b change on the edge that ends the key_valid cycle.
- clear:
  - Moves the FSM to ENTER_A; op_a and op_b are retained.
  - clear in the same cycle as key_valid: clear wins, the key is discarded (no operand write, no operands_ready), but key_code still updates.
  - clear does not disturb scanning or debounce.
- Reset mid-scan or mid-press: everything returns to reset values immediately (asynchronous). A key still held after reset is accepted normally once stable.
- All counters are free of overflow: the scan counter wraps at SCAN_DIV-1, the debounce counter saturates at DEBOUNCE_SCANS.

Decomposition:
- Shared package: entry-state encodings (ENTER_A=1'b0, ENTER_B=1'b1), scan-result encodings (NONE/SINGLE/MULTI), KEY_W=4.
- Sub-module keypad_scanner: synchronizer, column scan, result classification, debounce, press latch. Outputs key_valid and key_code.
- The top-level keypad_operand_entry holds the entry FSM and operand registers.

Test Plan:
All tests use SCAN_DIV=4 and DEBOUNCE_SCANS=3, with a keypad model that pulls a row low when its column is driven low.
1. Reset asserted mid-scan -> kp_cols=1110, op_a=op_b=0, entry_b=0 asynchronously; after release, kp_cols steps 1110->1101->1011->0111 every 4 cycles.
2. Hold row1/col2 for 6 scans -> exactly one key_valid with key_code=6; op_a=6 the following cycle; entry_b=1.
3. Bounce: key 9 present 2 scans, absent 1, present 3 -> no pulse during the bounce; a single key_valid with code 9 after the third clean scan.
4. Keys 3 and 12 pressed together for 10 scans -> no key_valid; op_a/op_b unchanged.
5. With op_a=6 loaded, hold key 15 for 20 scans -> one key_valid, op_b=15, operands_ready coincides with key_valid, entry_b=0; a re-press without 3 release scans yields no second pulse.
6. In ENTER_B, clear asserted in the key_valid cycle of key 5 -> entry_b=0, op_b unchanged, op_a=6 retained, no operands_ready, key_code=5.

Source files
------------

// File: rtl/keypad_operand_entry_pkg.sv
// Shared encodings for the keypad operand entry path: entry states, scan results
// and helpers that classify one full 4x4 keypad sample.
package keypad_operand_entry_pkg;

  localparam int unsigned KEY_W = 4;

  localparam logic ENTER_A = 1'b0;
  localparam logic ENTER_B = 1'b1;

  typedef enum logic [1:0] {
    ResNone   = 2'd0,
    ResSingle = 2'd1,
    ResMulti  = 2'd2
  } scan_res_e;

  // Bit index of low[] is 4*row + col, so a single set bit is directly the key code.
  function automatic scan_res_e classify_scan(input logic [15:0] low);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      n += 32'(low[i]);
    end
    if (n == 0) begin
      return ResNone;
    end else if (n == 1) begin
      return ResSingle;
    end
    return ResMulti;
  endfunction

  function automatic logic [KEY_W-1:0] lowest_code(input logic [15:0] low);
    logic [KEY_W-1:0] code;
    code = '0;
    for (int i = 15; i >= 0; i--) begin
      if (low[i]) begin
        code = KEY_W'(i);
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad reader: row synchronizer, per-scan classification,
// debounce and press latch producing one key_valid pulse per accepted press.
module keypad_scanner
  import keypad_operand_entry_pkg::*;
#(
  parameter int unsigned ScanDiv       = 5000,
  parameter int unsigned DebounceScans = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       kp_rows_i,
  output logic [3:0]       kp_cols_o,
  output logic             key_valid_o,
  output logic [KEY_W-1:0] key_code_o
);

  localparam int unsigned CntW = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;
  localparam int unsigned DbW  = $clog2(DebounceScans + 1);
  localparam logic [DbW-1:0] DbMax = DbW'(DebounceScans);

  logic [3:0]       rows_meta_q, rows_sync_q;
  logic [CntW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]       col_q, col_d;
  logic [15:0]      low_q, low_d, full_low;
  logic             pressed_q, pressed_d;
  logic [DbW-1:0]   stable_q, stable_d, stable_inc;
  logic [KEY_W-1:0] last_code_q, last_code_d;
  logic             key_valid_q, key_valid_d;
  logic [KEY_W-1:0] key_code_q, key_code_d;
  logic             slot_end, scan_done;
  scan_res_e        scan_res;
  logic [KEY_W-1:0] scan_code;

  assign slot_end   = (scan_cnt_q == CntW'(ScanDiv - 1));
  assign scan_done  = slot_end && (col_q == 2'd3);
  assign kp_cols_o  = ~(4'b0001 << col_q);
  assign stable_inc = (stable_q == DbMax) ? DbMax : stable_q + 1'b1;

  // Merge the current column's rows into the held sample so the column-3 slot
  // can classify the complete matrix on the same edge it is sampled.
  always_comb begin
    full_low = low_q;
    for (int r = 0; r < 4; r++) begin
      full_low[{2'(r), col_q}] = ~rows_sync_q[r];
    end
  end

  assign scan_res  = classify_scan(full_low);
  assign scan_code = lowest_code(full_low);

  always_comb begin
    scan_cnt_d = slot_end ? '0 : scan_cnt_q + 1'b1;
    col_d      = slot_end ? col_q + 2'd1 : col_q;
    low_d      = slot_end ? full_low : low_q;
  end

  always_comb begin
    pressed_d   = pressed_q;
    stable_d    = stable_q;
    last_code_d = last_code_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    if (scan_done) begin
      if (!pressed_q) begin
        if (scan_res == ResSingle) begin
          last_code_d = scan_code;
          // A non-zero count means the previous scan was a single key.
          if ((stable_q != '0) && (scan_code == last_code_q)) begin
            stable_d = stable_inc;
          end else begin
            stable_d = DbW'(1);
          end
          if (stable_d == DbMax) begin
            key_valid_d = 1'b1;
            key_code_d  = scan_code;
            pressed_d   = 1'b1;
            stable_d    = '0;
          end
        end else begin
          stable_d = '0;
        end
      end else begin
        stable_d = (scan_res == ResNone) ? stable_inc : '0;
        if (stable_d == DbMax) begin
          pressed_d = 1'b0;
          stable_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rows_meta_q <= 4'hF;
      rows_sync_q <= 4'hF;
      scan_cnt_q  <= '0;
      col_q       <= 2'd0;
      low_q       <= '0;
      pressed_q   <= 1'b0;
      stable_q    <= '0;
      last_code_q <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      rows_meta_q <= kp_rows_i;
      rows_sync_q <= rows_meta_q;
      scan_cnt_q  <= scan_cnt_d;
      col_q       <= col_d;
      low_q       <= low_d;
      pressed_q   <= pressed_d;
      stable_q    <= stable_d;
      last_code_q <= last_code_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;

endmodule

// File: rtl/keypad_operand_entry.sv
// Keypad operand entry: accepted keys load operand A then operand B alternately,
// with a one-cycle operands_ready pulse when B is written.
module keypad_operand_entry
  import keypad_operand_entry_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 5000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic             clk_main,
  input  logic             reset,
  input  logic [3:0]       kp_rows,
  output logic [3:0]       kp_cols,
  input  logic             clear,
  output logic [KEY_W-1:0] op_a,
  output logic [KEY_W-1:0] op_b,
  output logic             entry_b,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_code,
  output logic             operands_ready
);

  logic             entry_q, entry_d;
  logic [KEY_W-1:0] op_a_q, op_a_d;
  logic [KEY_W-1:0] op_b_q, op_b_d;

  keypad_scanner #(
    .ScanDiv      (SCAN_DIV),
    .DebounceScans(DEBOUNCE_SCANS)
  ) u_scanner (
    .clk_i      (clk_main),
    .rst_i      (reset),
    .kp_rows_i  (kp_rows),
    .kp_cols_o  (kp_cols),
    .key_valid_o(key_valid),
    .key_code_o (key_code)
  );

  // clear outranks a coincident key: the key is dropped but key_code still tracks it.
  always_comb begin
    entry_d = entry_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    if (clear) begin
      entry_d = ENTER_A;
    end else if (key_valid) begin
      if (entry_q == ENTER_A) begin
        op_a_d  = key_code;
        entry_d = ENTER_B;
      end else begin
        op_b_d  = key_code;
        entry_d = ENTER_A;
      end
    end
  end

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      entry_q <= ENTER_A;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      entry_q <= entry_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  assign op_a           = op_a_q;
  assign op_b           = op_b_q;
  assign entry_b        = entry_q;
  assign operands_ready = key_valid & (entry_q == ENTER_B) & ~clear;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Self-checking bench for keypad_operand_entry: scan-level keypad model, directed
// scenarios and randomized key/clear traffic compared every cycle.
module tb_keypad_operand_entry;

  localparam int unsigned SD = 4;
  localparam int unsigned DB = 3;

  logic       clk_main = 1'b0;
  logic       reset;
  logic       clear;
  logic [3:0] kp_rows, kp_cols, op_a, op_b, key_code;
  logic       entry_b, key_valid, operands_ready;
  logic [15:0] keys_down;

  always #5 clk_main = ~clk_main;

  // Matrix keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    kp_rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!kp_cols[c] && keys_down[4*r+c]) kp_rows[r] = 1'b0;
      end
    end
  end

  keypad_operand_entry #(
    .SCAN_DIV      (SD),
    .DEBOUNCE_SCANS(DB)
  ) dut (
    .clk_main      (clk_main),
    .reset         (reset),
    .kp_rows       (kp_rows),
    .kp_cols       (kp_cols),
    .clear         (clear),
    .op_a          (op_a),
    .op_b          (op_b),
    .entry_b       (entry_b),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .operands_ready(operands_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one entry per completed scan, judged over a window of scans.
  int          cyc;
  bit          chk_en;
  logic        exp_valid, exp_entry;
  logic [3:0]  exp_code, exp_a, exp_b;
  logic [15:0] scan_keys;
  int          hist[$];
  int          bound;
  bit          m_pressed;
  int          dut_valid_cnt = 0;
  int          dut_ready_cnt = 0;

  function automatic int classify(input logic [15:0] k);
    int n, code;
    n = 0;
    code = 0;
    for (int i = 0; i < 16; i++) begin
      if (k[i]) begin
        n++;
        code = i;
      end
    end
    if (n == 0) return -1;
    if (n > 1) return -2;
    return code;
  endfunction

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_entry = 1'b0;
    exp_code  = '0;
    exp_a     = '0;
    exp_b     = '0;
    hist.delete();
    bound     = 0;
    m_pressed = 1'b0;
    cyc       = 0;
  endtask

  task automatic scan_end();
    int r, n;
    bit ok;
    r = classify(scan_keys);
    hist.push_back(r);
    n = hist.size();
    if (n - bound >= int'(DB)) begin
      ok = 1'b1;
      for (int i = n - int'(DB); i < n; i++) begin
        if (!m_pressed) ok &= (hist[i] >= 0) && (hist[i] == r);
        else            ok &= (hist[i] == -1);
      end
      if (ok) begin
        if (!m_pressed) begin
          exp_valid = 1'b1;
          exp_code  = 4'(r);
        end
        m_pressed = !m_pressed;
        bound     = n;
      end
    end
  endtask

  task automatic tick();
    int   cur;
    logic clr;
    cur = cyc;
    clr = clear;
    @(posedge clk_main);
    #1;
    if (exp_valid && !clr) begin
      if (!exp_entry) exp_a = exp_code;
      else            exp_b = exp_code;
      exp_entry = !exp_entry;
    end else if (clr) begin
      exp_entry = 1'b0;
    end
    exp_valid = 1'b0;
    if (cur % 16 == 15) scan_end();
    cyc++;
  endtask

  // cmode: 0 no clear, 1 clear exactly on the key_valid cycle, 2 random clear pulses.
  task automatic run_scans(input logic [15:0] keys, input int n, input int cmode);
    for (int s = 0; s < n; s++) begin
      keys_down = keys;
      scan_keys = keys;
      for (int k = 0; k < 16; k++) begin
        if (cmode == 1)      clear = exp_valid;
        else if (cmode == 2) clear = ($urandom_range(0, 19) == 0);
        else                 clear = 1'b0;
        tick();
      end
    end
    clear = 1'b0;
  endtask

  always @(negedge clk_main) begin
    logic [3:0] ecols;
    logic       eready;
    if (chk_en) begin
      ecols  = ~(4'b0001 << ((cyc / 4) % 4));
      eready = exp_valid && exp_entry && !clear;
      check("kp_cols", 32'(kp_cols), 32'(ecols));
      check("key_valid", 32'(key_valid), 32'(exp_valid));
      check("key_code", 32'(key_code), 32'(exp_code));
      check("op_a", 32'(op_a), 32'(exp_a));
      check("op_b", 32'(op_b), 32'(exp_b));
      check("entry_b", 32'(entry_b), 32'(exp_entry));
      check("operands_ready", 32'(operands_ready), 32'(eready));
      if (key_valid === 1'b1) dut_valid_cnt++;
      if (operands_ready === 1'b1) dut_ready_cnt++;
    end
  end

  function automatic logic [15:0] key_bit(input int code);
    logic [15:0] one;
    one = 16'd1;
    return one << code;
  endfunction

  initial begin
    logic [3:0] col_pat [4];
    int v0, r0;
    logic [15:0] kk;
    int a, b, roll;
    col_pat = '{4'hE, 4'hD, 4'hB, 4'h7};
    reset = 1'b1;
    clear = 1'b0;
    keys_down = '0;
    scan_keys = '0;
    chk_en = 1'b0;
    model_reset();

    #12;
    check("rst_cols", 32'(kp_cols), 32'hE);
    check("rst_op_a", 32'(op_a), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    @(posedge clk_main);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;

    // Column walk after reset.
    for (int k = 0; k < 4; k++) begin
      check("col_walk", 32'(kp_cols), 32'(col_pat[k]));
      repeat (4) tick();
    end

    // Key 6 held for six scans loads A once.
    v0 = dut_valid_cnt;
    run_scans(key_bit(6), 6, 0);
    run_scans('0, 4, 0);
    check("t2_pulses", 32'(dut_valid_cnt - v0), 32'd1);
    check("t2_code", 32'(key_code), 32'd6);
    check("t2_op_a", 32'(op_a), 32'd6);
    check("t2_entry_b", 32'(entry_b), 32'd1);

    // Bouncing key 9: 2 on, 1 off, 3 on.
    v0 = dut_valid_cnt;
    r0 = dut_ready_cnt;
    run_scans(key_bit(9), 2, 0);
    run_scans('0, 1, 0);
    run_scans(key_bit(9), 2, 0);
    check("t3_no_bounce_pulse", 32'(dut_valid_cnt - v0), 32'd0);
    run_scans(key_bit(9), 2, 0);
    check("t3_pulses", 32'(dut_valid_cnt - v0), 32'd1);
    check("t3_op_b", 32'(op_b), 32'd9);
    check("t3_ready", 32'(dut_ready_cnt - r0), 32'd1);
    check("t3_entry_b", 32'(entry_b), 32'd0);
    run_scans('0, 4, 0);

    // Keys 3 and 12 together never emit.
    v0 = dut_valid_cnt;
    run_scans(key_bit(3) | key_bit(12), 10, 0);
    run_scans('0, 4, 0);
    check("t4_pulses", 32'(dut_valid_cnt - v0), 32'd0);
    check("t4_op_a", 32'(op_a), 32'd6);
    check("t4_op_b", 32'(op_b), 32'd9);

    // Reload A=6, then key 15 held long, then a short release and re-press.
    run_scans(key_bit(6), 4, 0);
    run_scans('0, 4, 0);
    v0 = dut_valid_cnt;
    r0 = dut_ready_cnt;
    run_scans(key_bit(15), 20, 0);
    check("t5_pulses", 32'(dut_valid_cnt - v0), 32'd1);
    check("t5_ready", 32'(dut_ready_cnt - r0), 32'd1);
    check("t5_op_b", 32'(op_b), 32'd15);
    check("t5_entry_b", 32'(entry_b), 32'd0);
    run_scans('0, 2, 0);
    run_scans(key_bit(15), 5, 0);
    check("t5_no_repress", 32'(dut_valid_cnt - v0), 32'd1);
    run_scans('0, 4, 0);

    // Clear coinciding with key 5 while in ENTER_B.
    run_scans(key_bit(6), 4, 0);
    run_scans('0, 4, 0);
    v0 = dut_valid_cnt;
    r0 = dut_ready_cnt;
    run_scans(key_bit(5), 4, 1);
    run_scans('0, 4, 0);
    check("t6_pulses", 32'(dut_valid_cnt - v0), 32'd1);
    check("t6_ready", 32'(dut_ready_cnt - r0), 32'd0);
    check("t6_entry_b", 32'(entry_b), 32'd0);
    check("t6_op_a", 32'(op_a), 32'd6);
    check("t6_op_b", 32'(op_b), 32'd15);
    check("t6_code", 32'(key_code), 32'd5);

    // Reset mid-scan with key 10 held; it is accepted again afterwards.
    keys_down = key_bit(10);
    scan_keys = keys_down;
    repeat (7) tick();
    chk_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_cols", 32'(kp_cols), 32'hE);
    check("mid_rst_op_a", 32'(op_a), 32'h0);
    check("mid_rst_op_b", 32'(op_b), 32'h0);
    check("mid_rst_entry", 32'(entry_b), 32'h0);
    check("mid_rst_code", 32'(key_code), 32'h0);
    model_reset();
    @(posedge clk_main);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    run_scans(key_bit(10), 5, 0);
    run_scans('0, 4, 0);
    check("rst_hold_op_a", 32'(op_a), 32'd10);
    check("rst_hold_entry", 32'(entry_b), 32'd1);

    // Randomized key traffic with sporadic clear pulses.
    repeat (60) begin
      roll = int'($urandom_range(0, 9));
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      if (roll < 5)      kk = '0;
      else if (roll < 9) kk = key_bit(a);
      else               kk = key_bit(a) | key_bit(b);
      run_scans(kk, int'($urandom_range(1, 6)), 2);
    end
    run_scans('0, 4, 0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
